// File: rtl/bsg_rr_f2f_credit_ctrl.sv
// bsg_rr_f2f_credit_ctrl: per-output credit tracking and drain-then-switch channel reconfiguration
module bsg_rr_f2f_credit_ctrl #(
  parameter int num_in_p = 2,
  parameter int num_out_p = 1,
  parameter int credits_p = 4,
  localparam int in_top_w = (num_in_p > 1) ? $clog2(num_in_p) : 1,
  localparam int out_top_w = (num_out_p > 1) ? $clog2(num_out_p) : 1,
  localparam int cnt_w = $clog2(credits_p + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [num_in_p-1:0]  valid_i,
  output logic [num_in_p-1:0]  f2f_valid_o,
  input  logic [num_out_p-1:0] f2f_valid_out_i,
  output logic [num_out_p-1:0] f2f_ready_o,
  input  logic [num_out_p-1:0] credit_i,
  input  logic                 cfg_v_i,
  input  logic [in_top_w-1:0]  cfg_in_top_i,
  input  logic [out_top_w-1:0] cfg_out_top_i,
  output logic                 cfg_yumi_o,
  output logic [in_top_w-1:0]  in_top_channel_o,
  output logic [out_top_w-1:0] out_top_channel_o,
  output logic                 f2f_reset_o,
  output logic                 busy_o,
  output logic                 credit_err_o
);
  typedef enum logic [1:0] {RUN, DRAIN, SWITCH} state_e;
  localparam logic [cnt_w-1:0] full = cnt_w'(credits_p);
  state_e state_q, state_d;
  logic [cnt_w-1:0] cnt_q [num_out_p];
  logic [cnt_w-1:0] cnt_d [num_out_p];
  logic [in_top_w-1:0] in_top_q, in_top_d, cfg_in_q, cfg_in_d;
  logic [out_top_w-1:0] out_top_q, out_top_d, cfg_out_q, cfg_out_d;
  logic err_q, err_d, all_full;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      for (int j = 0; j < num_out_p; j++) cnt_q[j] <= full;
      in_top_q <= in_top_w'(num_in_p - 1);
      out_top_q <= out_top_w'(num_out_p - 1);
      cfg_in_q <= '0;
      cfg_out_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      in_top_q <= in_top_d;
      out_top_q <= out_top_d;
      cfg_in_q <= cfg_in_d;
      cfg_out_q <= cfg_out_d;
      err_q <= err_d;
    end
  end
  // Counters saturate at both ends; any overflow or underflow latches the error flag.
  always_comb begin
    err_d = err_q;
    all_full = 1'b1;
    for (int j = 0; j < num_out_p; j++) begin
      cnt_d[j] = cnt_q[j];
      all_full = all_full & (cnt_q[j] == full);
      if (credit_i[j] & ~f2f_valid_out_i[j]) begin
        if (cnt_q[j] == full) err_d = 1'b1;
        else cnt_d[j] = cnt_q[j] + cnt_w'(1);
      end else if (f2f_valid_out_i[j] & ~credit_i[j]) begin
        if (cnt_q[j] == '0) err_d = 1'b1;
        else cnt_d[j] = cnt_q[j] - cnt_w'(1);
      end
    end
  end
  always_comb begin
    state_d = (state_q == RUN && cfg_v_i) ? DRAIN :
              (state_q == DRAIN && all_full) ? SWITCH :
              (state_q == SWITCH) ? RUN : state_q;
    cfg_in_d = (state_q == RUN && cfg_v_i) ? cfg_in_top_i : cfg_in_q;
    cfg_out_d = (state_q == RUN && cfg_v_i) ? cfg_out_top_i : cfg_out_q;
    in_top_d = (state_q == SWITCH) ? cfg_in_q : in_top_q;
    out_top_d = (state_q == SWITCH) ? cfg_out_q : out_top_q;
  end
  always_comb begin
    f2f_valid_o = (state_q == RUN) ? valid_i : '0;
    cfg_yumi_o = (state_q == SWITCH);
    f2f_reset_o = reset | (state_q == SWITCH);
    busy_o = (state_q != RUN);
    credit_err_o = err_q;
    in_top_channel_o = in_top_q;
    out_top_channel_o = out_top_q;
    for (int j = 0; j < num_out_p; j++) f2f_ready_o[j] = (cnt_q[j] != '0);
  end
endmodule

// File: tb/tb_bsg_rr_f2f_credit_ctrl.sv
// tb_bsg_rr_f2f_credit_ctrl: directed and random checks against a behavioural credit/config model
module tb_bsg_rr_f2f_credit_ctrl;
  localparam int NI = 2, NO = 1, CR = 4;
  logic clk = 0, reset;
  logic [NI-1:0] valid_i, f2f_valid_o;
  logic [NO-1:0] f2f_valid_out_i, f2f_ready_o, credit_i;
  logic cfg_v_i, cfg_yumi_o, f2f_reset_o, busy_o, credit_err_o;
  logic [0:0] cfg_in_top_i, cfg_out_top_i, in_top_channel_o, out_top_channel_o;
  int checks = 0, errors = 0;
  int m_state, m_cnt [NO], m_err, m_in, m_out, m_cin, m_cout;
  bit mvalid = 0;

  bsg_rr_f2f_credit_ctrl #(.num_in_p(NI), .num_out_p(NO), .credits_p(CR)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .f2f_valid_o(f2f_valid_o),
    .f2f_valid_out_i(f2f_valid_out_i), .f2f_ready_o(f2f_ready_o), .credit_i(credit_i),
    .cfg_v_i(cfg_v_i), .cfg_in_top_i(cfg_in_top_i), .cfg_out_top_i(cfg_out_top_i),
    .cfg_yumi_o(cfg_yumi_o), .in_top_channel_o(in_top_channel_o),
    .out_top_channel_o(out_top_channel_o), .f2f_reset_o(f2f_reset_o), .busy_o(busy_o),
    .credit_err_o(credit_err_o));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: state 0 = running, 1 = waiting for all credits home, 2 = one switch cycle.
  task automatic m_update();
    bit home = 1;
    for (int j = 0; j < NO; j++) home &= (m_cnt[j] == CR);
    if (reset) begin
      m_state = 0; m_err = 0; m_in = NI - 1; m_out = NO - 1;
      for (int j = 0; j < NO; j++) m_cnt[j] = CR;
      return;
    end
    for (int j = 0; j < NO; j++) begin
      int c = m_cnt[j] + int'(credit_i[j]) - int'(f2f_valid_out_i[j]);
      if (c > CR) begin c = CR; m_err = 1; end
      if (c < 0) begin c = 0; m_err = 1; end
      m_cnt[j] = c;
    end
    case (m_state)
      0: if (cfg_v_i) begin m_state = 1; m_cin = cfg_in_top_i; m_cout = cfg_out_top_i; end
      1: if (home) m_state = 2;
      default: begin m_in = m_cin; m_out = m_cout; m_state = 0; end
    endcase
  endtask

  task automatic cyc(input logic rst, input logic [NI-1:0] v, input logic [NO-1:0] vo,
                     input logic [NO-1:0] cr, input logic cv, input logic ci, input logic co);
    reset = rst; valid_i = v; f2f_valid_out_i = vo; credit_i = cr;
    cfg_v_i = cv; cfg_in_top_i = ci; cfg_out_top_i = co;
    @(posedge clk);
    m_update();
    mvalid = 1;
    #1;
  endtask

  always @(negedge clk) if (mvalid) begin
    chk("valid_o", 32'(f2f_valid_o), m_state == 0 ? 32'(valid_i) : 0);
    for (int j = 0; j < NO; j++) chk("ready_o", 32'(f2f_ready_o[j]), 32'(m_cnt[j] != 0));
    chk("yumi_o", 32'(cfg_yumi_o), 32'(m_state == 2));
    chk("f2f_reset_o", 32'(f2f_reset_o), 32'(reset | (m_state == 2)));
    chk("busy_o", 32'(busy_o), 32'(m_state != 0));
    chk("err_o", 32'(credit_err_o), 32'(m_err));
    chk("in_top", 32'(in_top_channel_o), 32'(m_in));
    chk("out_top", 32'(out_top_channel_o), 32'(m_out));
  end

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("lit_reset_f2f", 32'(f2f_reset_o), 1);
    chk("lit_reset_in_top", 32'(in_top_channel_o), 1);
    chk("lit_reset_ready", 32'(f2f_ready_o), 1);
    chk("lit_reset_busy", 32'(busy_o), 0);
    repeat (4) cyc(0, 0, 1, 0, 0, 0, 0);
    chk("lit_empty_ready", 32'(f2f_ready_o), 0);
    chk("lit_run_f2f", 32'(f2f_reset_o), 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("lit_credit_ready", 32'(f2f_ready_o), 1);
    cyc(0, 0, 0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 1, 0, 0, 0);
    chk("lit_both_err", 32'(credit_err_o), 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("lit_full_err", 32'(credit_err_o), 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("lit_overflow_err", 32'(credit_err_o), 1);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_err_sticky", 32'(credit_err_o), 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("lit_err_clear", 32'(credit_err_o), 0);
    repeat (3) cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 2'b11, 0, 0, 1, 0, 0);
    chk("lit_drain_busy", 32'(busy_o), 1);
    chk("lit_drain_valid", 32'(f2f_valid_o), 0);
    repeat (3) cyc(0, 2'b11, 0, 1, 0, 0, 0);
    chk("lit_drain_noyumi", 32'(cfg_yumi_o), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_switch_yumi", 32'(cfg_yumi_o), 1);
    chk("lit_switch_f2f", 32'(f2f_reset_o), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_new_in_top", 32'(in_top_channel_o), 0);
    chk("lit_new_f2f", 32'(f2f_reset_o), 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("lit_lat1_yumi", 32'(cfg_yumi_o), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_lat2_yumi", 32'(cfg_yumi_o), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_lat_in_top", 32'(in_top_channel_o), 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("lit_rst_drain_busy", 32'(busy_o), 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("lit_rst_busy", 32'(busy_o), 0);
    chk("lit_rst_yumi", 32'(cfg_yumi_o), 0);
    chk("lit_rst_in_top", 32'(in_top_channel_o), 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_rst_cnt_full", 32'(cfg_yumi_o), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [NO-1:0] vo, cr;
      for (int j = 0; j < NO; j++) begin
        vo[j] = (m_cnt[j] != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
        cr[j] = (m_cnt[j] != CR) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0);
      end
      cyc($urandom_range(0, 299) == 0, NI'($urandom), vo, cr, $urandom_range(0, 7) == 0,
          1'($urandom), 1'($urandom));
    end
    mvalid = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
